// File: rtl/operand_loader_pkg.sv
// Shared types and defaults for the operand loader and its helpers.
package operand_loader_pkg;

  // Loader sequencing: three word-load states, then hold and wait-for-ack.
  typedef enum logic [2:0] {
    LD_A = 3'd0,
    LD_B = 3'd1,
    LD_C = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_HOLD  = 1;

endpackage

// File: rtl/operand_loader_hold_timer.sv
// 4-bit loadable down-counter that times how long committed operands settle.
module hold_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       last
);

  logic [3:0] count_reg;

  // Load has priority; decrement only while enabled and never below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= 4'd0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != 4'd0)) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  // Last hold edge is the one on which the count reads 1.
  assign last = (count_reg == 4'd1);

endmodule

// File: rtl/operand_loader.sv
// Assembles a serial a, b, c word stream into a committed operand triple,
// holds it for the datapath and waits for the consumer acknowledge.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             op_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] triple_cnt
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sb_reg;
  logic [WIDTH-1:0] a_reg, b_reg, c_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             timer_load;
  logic             timer_last;
  logic             load_state;

  hold_timer u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (HOLD_LOAD),
    .en       (state_reg == HOLD),
    .last     (timer_last)
  );

  // State register, shadow words, committed operands and triple counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LD_A;
      sa_reg    <= '0;
      sb_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == LD_A) && in_valid) begin
        sa_reg <= in_data;
      end
      if ((state_reg == LD_B) && in_valid) begin
        sb_reg <= in_data;
      end
      // All three operands move together so no partial triple is visible.
      if ((state_reg == LD_C) && in_valid) begin
        a_reg <= sa_reg;
        b_reg <= sb_reg;
        c_reg <= in_data;
      end
      if ((state_reg == DONE) && res_ready) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // Next-state decode and hold-timer load.
  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    case (state_reg)
      LD_A: if (in_valid) state_next = LD_B;
      LD_B: if (in_valid) state_next = LD_C;
      LD_C: begin
        if (in_valid) begin
          state_next = HOLD;
          timer_load = 1'b1;
        end
      end
      HOLD: if (timer_last) state_next = DONE;
      DONE: if (res_ready) state_next = LD_A;
      default: state_next = LD_A;
    endcase
  end

  // Moore outputs decoded from state; in_ready also masked by reset.
  always_comb begin
    load_state = (state_reg == LD_A) || (state_reg == LD_B) || (state_reg == LD_C);
    in_ready   = load_state && !rst;
    op_valid   = (state_reg == HOLD) || (state_reg == DONE);
    res_valid  = (state_reg == DONE);
  end

  assign a          = a_reg;
  assign b          = b_reg;
  assign c          = c_reg;
  assign triple_cnt = cnt_reg;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench: two loader instances (default timing, and
// HOLD_CYCLES=3 with a 2-bit triple counter) exercised through one
// transaction task against a transaction-level model.
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic        sel = 1'b0;

  logic        iv0, iv1, rr0, rr1;
  logic        ir0, ir1, ov0, ov1, rv0, rv1;
  logic [31:0] a0, b0, c0, a1, b1, c1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  logic [31:0] oa, ob, oc;
  logic        oir, oov, orv;
  logic [15:0] ocnt;

  int errors = 0;
  int checks = 0;

  // Transaction-level model: last committed triple and count per instance.
  logic [31:0] ma [2];
  logic [31:0] mb [2];
  logic [31:0] mc [2];
  logic [15:0] mcnt [2];

  always #5 clk = ~clk;

  assign iv0 = in_valid & ~sel;
  assign iv1 = in_valid & sel;
  assign rr0 = res_ready & ~sel;
  assign rr1 = res_ready & sel;

  operand_loader dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(iv0), .in_ready(ir0),
    .a(a0), .b(b0), .c(c0), .op_valid(ov0), .res_valid(rv0),
    .res_ready(rr0), .triple_cnt(cnt0)
  );

  operand_loader #(.WIDTH(32), .HOLD_CYCLES(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .c(c1), .op_valid(ov1), .res_valid(rv1),
    .res_ready(rr1), .triple_cnt(cnt1)
  );

  always_comb begin
    if (sel) begin
      oa = a1; ob = b1; oc = c1; oir = ir1; oov = ov1; orv = rv1;
      ocnt = {14'd0, cnt1};
    end else begin
      oa = a0; ob = b0; oc = c0; oir = ir0; oov = ov0; orv = rv0;
      ocnt = cnt0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      ma[i] = '0; mb[i] = '0; mc[i] = '0; mcnt[i] = '0;
    end
  endtask

  // One full triple: words with optional gaps, hold timing, ack handling.
  task automatic run_triple(input logic s, input logic [31:0] wa, input logic [31:0] wb,
                            input logic [31:0] wc, input int gb, input int gc,
                            input int ad, input bit early);
    int h;
    h = s ? 3 : 1;
    sel = s;
    #1;
    chk("ready_ld_a", oir, 1);
    in_data = wa; in_valid = 1'b1;
    tick();
    chk("opv_after_a", oov, 0);
    chk("a_no_partial", oa, ma[s]);
    in_valid = 1'b0;
    for (int i = 0; i < gb; i++) begin
      tick();
      chk("ready_gap_b", oir, 1);
    end
    in_data = wb; in_valid = 1'b1;
    tick();
    chk("b_no_partial", ob, mb[s]);
    in_valid = 1'b0;
    for (int i = 0; i < gc; i++) begin
      tick();
      chk("c_no_partial_pause", oc, mc[s]);
      chk("opv_pause", oov, 0);
    end
    in_data = wc; in_valid = 1'b1;
    tick();
    ma[s] = wa; mb[s] = wb; mc[s] = wc;
    chk("commit_a", oa, ma[s]);
    chk("commit_b", ob, mb[s]);
    chk("commit_c", oc, mc[s]);
    chk("opv_commit", oov, 1);
    chk("ready_commit", oir, 0);
    chk("resv_commit", orv, 0);
    // Keep offering junk words while busy; they must be ignored.
    in_data = $urandom;
    res_ready = early;
    for (int k = 1; k <= h; k++) begin
      tick();
      chk("resv_timing", orv, (k == h) ? 1 : 0);
      chk("a_held_hold", oa, ma[s]);
      chk("ready_hold", oir, 0);
    end
    if (!early) begin
      for (int i = 0; i < ad; i++) begin
        tick();
        chk("resv_wait", orv, 1);
        chk("opv_wait", oov, 1);
        chk("ready_wait", oir, 0);
        chk("c_held_wait", oc, mc[s]);
      end
      res_ready = 1'b1;
    end
    tick();
    mcnt[s] = (mcnt[s] + 16'd1) & (s ? 16'h0003 : 16'hFFFF);
    in_valid = 1'b0; res_ready = 1'b0;
    chk("triple_cnt", ocnt, mcnt[s]);
    chk("resv_after_ack", orv, 0);
    chk("opv_after_ack", oov, 0);
    chk("ready_after_ack", oir, 1);
    chk("b_held_after_ack", ob, mb[s]);
    $display("triple sel=%0d a=%0h b=%0h c=%0h cnt=%0d", s, wa, wb, wc, ocnt);
  endtask

  typedef struct {
    logic        s;
    logic [31:0] wa, wb, wc;
    int          gb, gc, ad;
    bit          early;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b0, 32'd5, 32'd3, 32'd7, 0, 0, 0, 1'b0, 16'd1};
    tbl[1] = '{1'b0, 32'd5, 32'd3, 32'd7, 0, 4, 0, 1'b0, 16'd2};
    tbl[2] = '{1'b0, 32'hFFFFFFFF, 32'h0, 32'h80000001, 2, 1, 6, 1'b0, 16'd3};
    tbl[3] = '{1'b0, 32'hDEADBEEF, 32'h12345678, 32'h0, 0, 0, 0, 1'b1, 16'd4};
    tbl[4] = '{1'b1, 32'd10, 32'd20, 32'd30, 0, 0, 0, 1'b0, 16'd1};
    tbl[5] = '{1'b1, 32'd11, 32'd21, 32'd31, 1, 0, 2, 1'b0, 16'd2};
    tbl[6] = '{1'b1, 32'd12, 32'd22, 32'd32, 0, 0, 0, 1'b1, 16'd3};
    tbl[7] = '{1'b1, 32'd13, 32'd23, 32'd33, 0, 2, 1, 1'b0, 16'd0};
    tbl[8] = '{1'b1, 32'd14, 32'd24, 32'd34, 0, 0, 0, 1'b0, 16'd1};

    model_clear();
    rst = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_in_ready", oir, 0);
      chk("rst_a", oa, 0);
      chk("rst_opv", oov, 0);
      chk("rst_resv", orv, 0);
      chk("rst_cnt", ocnt, 0);
    end
    rst = 1'b0;

    // Directed table, including the wrap of the 2-bit counter.
    for (int i = 0; i < 9; i++) begin
      run_triple(tbl[i].s, tbl[i].wa, tbl[i].wb, tbl[i].wc,
                 tbl[i].gb, tbl[i].gc, tbl[i].ad, tbl[i].early);
      chk("tbl_cnt", ocnt, tbl[i].exp_cnt);
    end

    // Randomised triples on both instances.
    for (int i = 0; i < 24; i++) begin
      run_triple(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset after two words of a triple discards the partial load.
    sel = 1'b0;
    in_data = 32'd9; in_valid = 1'b1;
    tick();
    in_data = 32'd10;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", oir, 0);
    tick();
    model_clear();
    chk("rst_mid_a", oa, 0);
    chk("rst_mid_b", ob, 0);
    chk("rst_mid_c", oc, 0);
    chk("rst_mid_opv", oov, 0);
    chk("rst_mid_resv", orv, 0);
    chk("rst_mid_cnt", ocnt, 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready_back", oir, 1);
    run_triple(1'b0, 32'd1, 32'd1, 32'd1, 0, 0, 0, 1'b0);
    chk("post_rst_cnt", ocnt, 16'd1);
    chk("post_rst_a", oa, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream feeder for the three-operand compare/shift datapath. It accepts a serial stream of WIDTH-bit words over a valid/ready handshake and assembles them into the a, b, c triple. It commits all three operands to its outputs on the same edge and holds them stable while the datapath's output registers settle. It then raises a result-valid flag and waits for the consumer to acknowledge before loading the next triple.

## Interface
- WIDTH, 32, word and operand width.
- HOLD_CYCLES, 1, clock edges between operand commit and results valid; matches the datapath's single output register stage; legal range 1..15.
- CNT_W, 16, width of the triple counter.

- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  WIDTH  serial operand word, in order a, b, c.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a word this cycle.
- a, b, c  output  WIDTH  committed operands to the datapath.
- op_valid  output  1  a/b/c hold a committed triple; high in HOLD and DONE.
- res_valid  output  1  datapath x/z outputs are valid for the current triple.
- res_ready  input  1  consumer has taken x/z.
- triple_cnt  output  CNT_W  number of completed triples; wraps modulo 2^CNT_W.

## Operation
- States: LD_A, LD_B, LD_C, HOLD, DONE. The reset state is LD_A.
- A word is accepted on a clock edge where in_valid and in_ready are both high.
- in_ready is 1 in LD_A, LD_B and LD_C, and 0 in HOLD and DONE. It is forced to 0 while rst is high.
- LD_A: an accepted word is written to shadow register sa, and the state moves to LD_B.
- LD_B: an accepted word is written to shadow register sb, and the state moves to LD_C.
- LD_C: an accepted word triggers a commit on that same edge:
  - a<=sa, b<=sb, c<=in_data;
  - the hold counter loads HOLD_CYCLES;
  - the state moves to HOLD.
- a, b and c change only on a commit edge. Partial loads never appear at the outputs.
- HOLD: the counter decrements each edge. When it reaches 1, the state moves to DONE on that edge.
- DONE: res_valid=1 and a/b/c stay held. If res_ready=1 on an edge:
  - triple_cnt increments;
  - the state moves to LD_A.
- In LD_A/B/C with in_valid=0, the state and shadow registers hold.
- triple_cnt wrap: all-ones + 1 gives 0. No flag is raised.
- Reset mid-operation, in any state, on the next edge:
  - the state goes to LD_A;
  - sa, sb, a, b, c and the counter clear to 0;
  - triple_cnt clears to 0;
  - any partially loaded triple is discarded.

## Timing
- Reset values: a=b=c=0, op_valid=0, res_valid=0, in_ready=0 during reset, triple_cnt=0.
- Throughput: 3 accept cycles + HOLD_CYCLES + at least 1 DONE cycle per triple. With defaults and back-to-back valid/ready, this is 5 cycles.
- Commit edge T: a/b/c are new from T. op_valid=1 from T.
- Results: res_valid=1 from edge T+HOLD_CYCLES. The datapath registers x/z at edge T+1, so x/z are valid whenever res_valid=1.
- Outputs: op_valid, res_valid and in_ready are Moore outputs, decoded from state only (in_ready is additionally gated by rst). There is no combinational path from in_valid or res_ready to any output.
- Acknowledge: res_ready may be high before DONE. It is ignored outside DONE, and DONE still lasts at least 1 cycle.
- Simultaneous events: rst=1 overrides every handshake in the same cycle.

## Structure
- Shared package holds:
  - the state enum (LD_A, LD_B, LD_C, HOLD, DONE), 3 bits;
  - default constants DEF_WIDTH=32 and DEF_HOLD=1.
- Sub-module hold_timer: a 4-bit loadable down-counter.
  - Inputs: load, load value, enable.
  - Output: a last flag, asserted when count==1.
  - Used for the HOLD state.
- The FSM, shadow registers and triple counter live in operand_loader.

## Test plan
- Reset, then stream 5, 3, 7 with in_valid held high.
  - in_ready high for 3 cycles, then low.
  - a/b/c = 5/3/7 on the same edge.
  - res_valid one edge later.
  - With the datapath attached: x=16, z=2.
- Stream 5, 3 and pause 4 cycles before sending 7.
  - a/b/c stay 0 throughout the pause.
  - Commit occurs only when 7 is accepted.
- Hold res_ready=0 for 6 cycles in DONE.
  - res_valid, a/b/c and op_valid are stable.
  - in_ready stays 0.
  - Raising res_ready gives triple_cnt 0->1 and LD_A.
- Assert rst for 1 cycle after 2 words.
  - All outputs read 0 and the state is LD_A.
  - The next 3 words 1, 1, 1 give a/b/c=1/1/1 and triple_cnt=1.
- With CNT_W=2, run 5 triples: triple_cnt sequence 1, 2, 3, 0, 1.
- With HOLD_CYCLES=3, res_valid rises exactly 3 edges after commit.
